// File: rtl/counter_checker_if.sv
// counter_checker_if -- bundles the observed-counter signals and the checker
// results so the checker and its environment share one port.
//   enable, data, clear : driven by the environment (master)
//   locked, mismatch, expected, err_count, wrap_count : driven by the checker
//   state               : checker FSM state, exposed for debug/assertion binding
// Handshake: there is no valid/ready pair; every field is sampled on each
// rising clk edge, so the environment must hold inputs stable around the edge.
interface counter_checker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             enable;
  logic [WIDTH-1:0] data;
  logic             clear;
  logic             locked;
  logic             mismatch;
  logic [WIDTH-1:0] expected;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] wrap_count;
  logic [1:0]       state;

  modport master (
    output enable, data, clear,
    input  locked, mismatch, expected, err_count, wrap_count, state
  );

  modport slave (
    input  enable, data, clear,
    output locked, mismatch, expected, err_count, wrap_count, state
  );
endinterface

// File: rtl/counter_checker.sv
// counter_checker -- watches an up-counter with enable and checks that it obeys
// data(n+1) = data(n) + enable(n) (mod 2^WIDTH).
//   clk      : clock, all sampling on the rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of counter_checker_if
//     inputs  enable, data, clear
//     outputs locked (tracking), mismatch (one-cycle error pulse),
//             expected (prediction of next data), err_count / wrap_count
//             (saturating statistics), state (FSM debug view)
// After reset the checker captures one sample (IDLE), then needs LOCK_COUNT
// consecutive good steps (SYNC) before it reports errors (LOCKED).
module counter_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input logic              clk,
  input logic              reset_n,
  counter_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_COUNT);

  state_t           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic [3:0]       run_inc;
  logic [WIDTH-1:0] prev_q;
  logic             prev_en_q;
  logic [WIDTH-1:0] expected_q;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] err_q, wrap_q;
  logic             err_inc, wrap_inc;
  logic [WIDTH-1:0] predicted;
  logic             match;
  logic             wrap_hit;

  // Prediction made from the previous sample; the hold case (enable = 0)
  // predicts an unchanged value and therefore counts as a match.
  assign predicted = prev_q + WIDTH'(prev_en_q);
  assign match     = (bus.data == predicted);
  assign wrap_hit  = (prev_q == '1) && prev_en_q && (bus.data == '0);
  assign run_inc   = run_q + 4'd1;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Next-state logic, plus the per-edge events that depend on it
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    mismatch_d = 1'b0;
    err_inc    = 1'b0;
    wrap_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        // First edge only captures prev; no comparison is meaningful yet.
        state_d = SYNC;
        run_d   = '0;
      end
      SYNC: begin
        if (match) begin
          run_d = run_inc;
          if (run_inc == LOCK_RUN) state_d = LOCKED;
        end else begin
          run_d = '0;
        end
      end
      LOCKED: begin
        if (match) begin
          wrap_inc = wrap_hit;
        end else begin
          mismatch_d = 1'b1;
          err_inc    = 1'b1;
          state_d    = SYNC;
          run_d      = '0;
        end
      end
      default: begin
        state_d = IDLE;
        run_d   = '0;
      end
    endcase
  end

  // Datapath and statistics; clear beats a coincident increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      prev_en_q  <= 1'b0;
      expected_q <= '0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      wrap_q     <= '0;
    end else begin
      prev_q     <= bus.data;
      prev_en_q  <= bus.enable;
      expected_q <= bus.data + WIDTH'(bus.enable);
      mismatch_q <= mismatch_d;
      if (bus.clear)                  err_q <= '0;
      else if (err_inc && err_q != '1) err_q <= err_q + 1'b1;
      if (bus.clear)                    wrap_q <= '0;
      else if (wrap_inc && wrap_q != '1) wrap_q <= wrap_q + 1'b1;
    end
  end

  // Output logic
  always_comb begin
    bus.locked     = (state_q == LOCKED);
    bus.state      = state_q;
    bus.mismatch   = mismatch_q;
    bus.expected   = expected_q;
    bus.err_count  = err_q;
    bus.wrap_count = wrap_q;
  end

endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker -- directed and randomized stimulus for counter_checker.
// Two instances (CNT_W=8 and CNT_W=2) see identical inputs so statistics
// saturation can be observed alongside normal counting.
module tb_counter_checker;

  localparam int W    = 4;
  localparam int MODV = 16;
  localparam int LOCK = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  counter_checker_if #(.WIDTH(W), .CNT_W(8)) if1 ();
  counter_checker_if #(.WIDTH(W), .CNT_W(2)) if2 ();

  assign if2.enable = if1.enable;
  assign if2.data   = if1.data;
  assign if2.clear  = if1.clear;

  counter_checker #(.WIDTH(W), .LOCK_COUNT(LOCK), .CNT_W(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1)
  );
  counter_checker #(.WIDTH(W), .LOCK_COUNT(LOCK), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(if2)
  );

  // ---------------- reference model ----------------
  // Behavioural: remembers the last sample, a streak of good steps and raw
  // event totals since the last clear; saturation is applied when reading.
  int m_started, m_locked, m_streak, m_pd, m_pe, m_exp, m_mis;
  int m_err_raw, m_wrap_raw;
  int tb_d, tb_e;

  function automatic int sat(input int raw, input int bits);
    int lim;
    lim = (1 << bits) - 1;
    return (raw > lim) ? lim : raw;
  endfunction

  task automatic model_reset();
    m_started = 0; m_locked = 0; m_streak = 0; m_pd = 0; m_pe = 0;
    m_exp = 0; m_mis = 0; m_err_raw = 0; m_wrap_raw = 0;
  endtask

  task automatic model_step(input int d, input int e, input int c);
    int good;
    m_mis = 0;
    if (!m_started) begin
      m_started = 1;
      m_streak  = 0;
    end else begin
      good = (d == (m_pd + m_pe) % MODV);
      if (m_locked) begin
        if (good) begin
          if (m_pd == MODV - 1 && m_pe == 1 && d == 0) m_wrap_raw++;
        end else begin
          m_mis = 1; m_err_raw++; m_locked = 0; m_streak = 0;
        end
      end else if (good) begin
        m_streak++;
        if (m_streak >= LOCK) m_locked = 1;
      end else begin
        m_streak = 0;
      end
    end
    if (c != 0) begin
      m_err_raw = 0; m_wrap_raw = 0;
    end
    m_pd  = d;
    m_pe  = e;
    m_exp = (d + e) % MODV;
  endtask

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("locked",     32'(if1.locked),     32'(m_locked));
    check("locked2",    32'(if2.locked),     32'(m_locked));
    check("mismatch",   32'(if1.mismatch),   32'(m_mis));
    check("expected",   32'(if1.expected),   32'(e));
    check("err_count",  32'(if1.err_count),  32'(sat(m_err_raw, 8)));
    check("wrap_count", 32'(if1.wrap_count), 32'(sat(m_wrap_raw, 8)));
    check("err_sat2",   32'(if2.err_count),  32'(sat(m_err_raw, 2)));
    check("wrap_sat2",  32'(if2.wrap_count), 32'(sat(m_wrap_raw, 2)));
  endtask

  // ---------------- driver tasks ----------------
  // Called shortly after a rising edge; inputs settle well before the next one.
  task automatic cycle(input int d, input int e, input int c);
    if1.data   = W'(d);
    if1.enable = e[0];
    if1.clear  = c[0];
    tb_d = d;
    tb_e = e;
    @(posedge clk);
    #1;
    if (!reset_n) model_reset();
    else model_step(d, e, c);
    exp_q.push_back(W'(m_exp));
    check_all();
  endtask

  task automatic good_steps(input int n);
    for (int i = 0; i < n; i++) cycle((tb_d + tb_e) % MODV, 1, 0);
  endtask

  task automatic bad_step(input int c);
    cycle((tb_d + tb_e + 5) % MODV, 1, c);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nd, ne, nc;
    reset_n    = 1'b0;
    if1.data   = W'(7);
    if1.enable = 1'b0;
    if1.clear  = 1'b0;
    tb_d = 7; tb_e = 0;
    model_reset();

    // Reset held: outputs stay 0 while enable toggles.
    for (int i = 0; i < 4; i++) cycle(7, i % 2, 0);

    // Lock: one capture edge plus four matching hold steps.
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0);
      if (i == 3) check("not_locked_edge4", 32'(if1.locked), 32'd0);
    end
    check("locked_edge5", 32'(if1.locked), 32'd1);
    check("err_after_lock", 32'(if1.err_count), 32'd0);

    // Wrap: count 0..15,0,1 with enable high.
    for (int i = 0; i < 18; i++) begin
      cycle(i % MODV, 1, 0);
      check("wrap_no_mismatch", 32'(if1.mismatch), 32'd0);
      check("wrap_expected", 32'(if1.expected), 32'((i + 1) % MODV));
    end
    check("wrap_once", 32'(if1.wrap_count), 32'd1);

    // Error: step to 5, then sample 9 instead of 6.
    for (int v = 2; v <= 5; v++) cycle(v, 1, 0);
    cycle(9, 1, 0);
    check("err_pulse", 32'(if1.mismatch), 32'd1);
    check("err_count1", 32'(if1.err_count), 32'd1);
    check("err_unlock", 32'(if1.locked), 32'd0);
    good_steps(1);
    check("pulse_one_cycle", 32'(if1.mismatch), 32'd0);
    good_steps(3);
    check("relock", 32'(if1.locked), 32'd1);

    // Clear at the same edge as a LOCKED mismatch.
    bad_step(1);
    check("clr_pulse", 32'(if1.mismatch), 32'd1);
    check("clr_wins", 32'(if1.err_count), 32'd0);

    // Saturation: five errors, each after relocking.
    for (int k = 0; k < 5; k++) begin
      good_steps(4);
      bad_step(0);
    end
    check("err_cnt8_5", 32'(if1.err_count), 32'd5);
    check("err_cnt2_sat", 32'(if2.err_count), 32'd3);

    // Async reset between edges while locked.
    good_steps(4);
    check("locked_pre_rst", 32'(if1.locked), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_locked", 32'(if1.locked), 32'd0);
    check("async_expected", 32'(if1.expected), 32'd0);
    check("async_err", 32'(if1.err_count), 32'd0);
    check("async_wrap", 32'(if1.wrap_count), 32'd0);
    check("async_mismatch", 32'(if1.mismatch), 32'd0);
    model_reset();
    exp_q.delete();
    cycle(3, 1, 0);
    reset_n = 1'b1;

    // Randomized: mostly legal counting, occasional glitches and clears.
    for (int i = 0; i < 300; i++) begin
      ne = int'($urandom_range(0, 1));
      nd = (tb_d + tb_e) % MODV;
      if ($urandom_range(0, 9) == 0) nd = int'($urandom_range(0, MODV - 1));
      nc = ($urandom_range(0, 24) == 0) ? 1 : 0;
      cycle(nd, ne, nc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_checker.md
COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of observed counter value.
REQ-002 SHALL have parameter LOCK_COUNT, default 4: consecutive good comparisons required to lock; legal range 1..15.
REQ-003 SHALL have parameter CNT_W, default 8: width of statistics counters.
REQ-004 SHALL have one clock and an asynchronous active-low reset; ports clk and reset_n.
REQ-005 SHALL have port: clk  input  1  clock; all sampling on rising edge.
REQ-006 SHALL have port: reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port: enable  input  1  enable seen by the observed counter.
REQ-008 SHALL have port: data  input  WIDTH  observed counter output.
REQ-009 SHALL have port: clear  input  1  synchronous clear of err_count and wrap_count.
REQ-010 SHALL have port: locked  output  1  checker is tracking the counter.
REQ-011 SHALL have port: mismatch  output  1  one-cycle error pulse.
REQ-012 SHALL have port: expected  output  WIDTH  predicted next data value.
REQ-013 SHALL have port: err_count  output  CNT_W  saturating mismatch count.
REQ-014 SHALL have port: wrap_count  output  CNT_W  saturating wrap count.

Function
REQ-015 SHALL model the counter rule: data(n+1) = (data(n) + enable(n)) mod 2^WIDTH, with both inputs sampled at each rising clk edge.
REQ-016 SHALL register prev = data and prev_en = enable at every edge in every state.
REQ-017 SHALL update expected to (data + enable) mod 2^WIDTH at every edge.
REQ-018 SHALL implement states IDLE, SYNC and LOCKED, plus a run counter.
REQ-019 IDLE: SHALL go to SYNC with run = 0 at the first edge after reset release; no comparison in IDLE.
REQ-020 SYNC, match (data == prev + prev_en): SHALL increment run; when run reaches LOCK_COUNT, SHALL go to LOCKED.
REQ-021 SYNC, mismatch: SHALL set run = 0 and stay in SYNC; no mismatch pulse and no err_count change.
REQ-022 LOCKED, match: SHALL stay in LOCKED.
REQ-023 LOCKED, mismatch: at that edge SHALL set mismatch = 1, increment err_count, go to SYNC, and set run = 0.
REQ-024 mismatch SHALL be registered, high for exactly the one cycle after the detecting edge, and 0 otherwise.
REQ-025 locked SHALL be 1 exactly while state == LOCKED.
REQ-026 Wrap: in LOCKED, a match with prev = 2^WIDTH-1, prev_en = 1 and data = 0 SHALL increment wrap_count.
REQ-027 err_count and wrap_count SHALL saturate at 2^CNT_W-1 and never roll over.
REQ-028 clear SHALL zero both counters at the edge where it is sampled high.
REQ-029 When clear and an increment occur at the same edge, clear SHALL win (result 0).
REQ-030 clear SHALL NOT affect state, run, mismatch, locked or expected.
REQ-031 Hold case (enable = 0, data unchanged) SHALL count as a match.

Reset
REQ-032 reset_n low SHALL immediately force state = IDLE, run = 0, prev = 0, prev_en = 0, expected = 0, locked = 0, mismatch = 0, err_count = 0 and wrap_count = 0, independent of clk.
REQ-033 Reset asserted mid-LOCKED or mid-pulse SHALL cancel the pulse and the lock; after release, the checker SHALL relock only via IDLE and SYNC.

Verification (WIDTH=4, LOCK_COUNT=4)
REQ-034 Reset: reset_n=0 with data=7 and enable=1 toggling -> all outputs 0 and locked=0 throughout.
REQ-035 Lock: release reset, data=0, enable=0 held -> locked=1 after edge 5 (1 capture + 4 matches) and err_count=0.
REQ-036 Wrap: locked, enable=1, data stepping 0..15,0,1 -> wrap_count=1, mismatch never set, expected tracks data+1.
REQ-037 Error: locked at data=5 with enable=1, next sample data=9 -> one-cycle mismatch, err_count=1, locked=0; 4 good steps -> locked=1.
REQ-038 Clear collision: clear=1 at the same edge as a LOCKED mismatch -> err_count=0 and mismatch still pulses; CNT_W=2 with 5 errors -> err_count=3.
REQ-039 Async reset mid-run: reset_n falls between edges while locked=1 -> locked, counters and expected are 0 before the next clk edge.
